// File: rtl/counter_stream_if.sv
// Valid/ready stream carrying counter words plus slice/frame position markers.
interface counter_stream_if #(
  parameter int CNT_WIDTH = 32,
  parameter int SLICE_W   = 2,
  parameter int IDX_W     = 4
);
  logic [CNT_WIDTH-1:0] counter;
  logic                 counter_valid;
  logic                 counter_ready;
  logic                 last_in_slice;
  logic                 last_in_frame;
  logic [SLICE_W-1:0]   slice_idx;
  logic [IDX_W-1:0]     counter_idx;

  modport master (
    output counter, counter_valid, last_in_slice, last_in_frame, slice_idx, counter_idx,
    input  counter_ready
  );

  modport slave (
    input  counter, counter_valid, last_in_slice, last_in_frame, slice_idx, counter_idx,
    output counter_ready
  );
endinterface

// File: rtl/counter_stream_gen.sv
// Counter-stream source: frames of NUM_SLICE x NUM_COUNTER words in one of four
// data modes, with backpressure, multi-frame runs, abort and a done pulse.
module counter_stream_gen #(
  parameter int          CNT_WIDTH     = 32,
  parameter int          NUM_COUNTER   = 10,
  parameter int          NUM_SLICE     = 3,
  parameter int          SPARSE_STRIDE = 4,
  parameter logic [31:0] LFSR_SEED     = 32'hACE10001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [7:0]       frames,
  output logic             busy,
  output logic             done,
  counter_stream_if.master m_if
);
  localparam int SW = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
  localparam int CW = (NUM_COUNTER > 1) ? $clog2(NUM_COUNTER) : 1;
  localparam logic [31:0]   TAPS       = 32'h80200003;
  localparam logic [SW-1:0] LAST_SLICE = SW'(NUM_SLICE - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(NUM_COUNTER - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t               state_r;
  logic [1:0]           mode_r;
  logic [7:0]           frames_r;
  logic [7:0]           frame_cnt_r;
  logic [CNT_WIDTH-1:0] seq_r;
  logic [31:0]          lfsr_r;
  logic [CNT_WIDTH-1:0] counter_r;
  logic                 valid_r;
  logic                 lis_r;
  logic                 lif_r;
  logic [SW-1:0]        slice_r;
  logic [CW-1:0]        cidx_r;
  logic                 busy_r;
  logic                 done_r;

  logic [CW-1:0]        cidx_nxt_s;
  logic [SW-1:0]        slice_nxt_s;
  logic [CNT_WIDTH-1:0] seq_nxt_s;
  logic [31:0]          lfsr_nxt_s;
  logic                 xfer_s;
  logic                 run_end_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] word_of(
    input logic [1:0]           md,
    input logic [CNT_WIDTH-1:0] sq,
    input logic [CNT_WIDTH-1:0] lf,
    input logic [SW-1:0]        sl,
    input logic [CW-1:0]        ci
  );
    logic [CNT_WIDTH-1:0] w;
    case (md)
      2'd0:    w = sq;
      2'd1:    w = CNT_WIDTH'(32'(sl) + 32'd1);
      2'd2:    w = lf;
      2'd3:    w = ((32'(ci) % 32'(SPARSE_STRIDE)) == 32'd0) ? sq : '0;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Position, sequence and LFSR values for the word following an accepted transfer.
  always_comb begin
    cidx_nxt_s  = cidx_r;
    slice_nxt_s = slice_r;
    if (cidx_r == LAST_CNT) begin
      cidx_nxt_s = '0;
      if (slice_r == LAST_SLICE) begin
        slice_nxt_s = '0;
      end else begin
        slice_nxt_s = slice_r + SW'(1);
      end
    end else begin
      cidx_nxt_s  = cidx_r + CW'(1);
      slice_nxt_s = slice_r;
    end
    seq_nxt_s  = seq_r + CNT_WIDTH'(1);
    lfsr_nxt_s = lfsr_step(lfsr_r);
    xfer_s     = valid_r & m_if.counter_ready;
    run_end_s  = (frames_r != 8'd0) && ((frame_cnt_r + 8'd1) == frames_r);
  end

  // Control FSM and all registered stream/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mode_r      <= 2'd0;
      frames_r    <= 8'd0;
      frame_cnt_r <= 8'd0;
      seq_r       <= '0;
      lfsr_r      <= LFSR_SEED;
      counter_r   <= '0;
      valid_r     <= 1'b0;
      lis_r       <= 1'b0;
      lif_r       <= 1'b0;
      slice_r     <= '0;
      cidx_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Abort wins over a coincident start.
          if (!abort && start) begin
            mode_r      <= mode;
            frames_r    <= frames;
            frame_cnt_r <= 8'd0;
            seq_r       <= '0;
            lfsr_r      <= LFSR_SEED;
            slice_r     <= '0;
            cidx_r      <= '0;
            counter_r   <= word_of(mode, '0, LFSR_SEED[CNT_WIDTH-1:0], '0, '0);
            lis_r       <= (LAST_CNT == '0);
            lif_r       <= (LAST_CNT == '0) && (LAST_SLICE == '0);
            valid_r     <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (abort) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (xfer_s) begin
            seq_r     <= seq_nxt_s;
            lfsr_r    <= lfsr_nxt_s;
            cidx_r    <= cidx_nxt_s;
            slice_r   <= slice_nxt_s;
            counter_r <= word_of(mode_r, seq_nxt_s, lfsr_nxt_s[CNT_WIDTH-1:0],
                                 slice_nxt_s, cidx_nxt_s);
            lis_r     <= (cidx_nxt_s == LAST_CNT);
            lif_r     <= (cidx_nxt_s == LAST_CNT) && (slice_nxt_s == LAST_SLICE);
            if (lif_r) begin
              frame_cnt_r <= frame_cnt_r + 8'd1;
              valid_r     <= 1'b0;
              if (run_end_s) begin
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                state_r <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            valid_r <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_if.counter       = counter_r;
  assign m_if.counter_valid = valid_r;
  assign m_if.last_in_slice = lis_r;
  assign m_if.last_in_frame = lif_r;
  assign m_if.slice_idx     = slice_r;
  assign m_if.counter_idx   = cidx_r;
  assign busy               = busy_r;
  assign done               = done_r;
endmodule

// File: tb/tb_counter_stream_gen.sv
// Randomised self-checking bench for counter_stream_gen against a word-index reference model.
module tb_counter_stream_gen;
  localparam int          NC   = 10;
  localparam int          NS   = 3;
  localparam int          FW   = NC * NS;
  localparam logic [31:0] SEED = 32'hACE10001;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [7:0] frames;
  logic       busy;
  logic       done;
  int         checks = 0;
  int         failures = 0;
  logic [31:0] run1_q[$];

  counter_stream_if #(.CNT_WIDTH(32), .SLICE_W(2), .IDX_W(4)) sif ();

  counter_stream_gen dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .mode   (mode),
    .frames (frames),
    .busy   (busy),
    .done   (done),
    .m_if   (sif)
  );

  always #5 clk = ~clk;

  // Word k of a run (counted from the run's first word) from the mode rules.
  function automatic logic [31:0] ref_word(input int md, input int k);
    int sl;
    int ci;
    logic [31:0] l;
    sl = (k % FW) / NC;
    ci = k % NC;
    l  = SEED;
    for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    case (md)
      0:       return 32'(k);
      1:       return 32'(sl + 1);
      2:       return l;
      default: return (ci % 4 == 0) ? 32'(k) : 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] md, input logic [7:0] nfr);
    mode   = md;
    frames = nfr;
    start  = 1'b1;
    step();
    start  = 1'b0;
    checks++;
    if (sif.counter_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_latency valid=%b busy=%b required valid=1 busy=1", sif.counter_valid, busy);
    end
  endtask

  // Streams nwords transfers with a ready pattern (0 always, 1 toggle, 2 random),
  // checking every accepted word and stall stability; counts valid-low cycles.
  task automatic run_stream(input int md, input int nwords, input int pat, input bit rec,
                            output int low_cycles);
    int k = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [38:0] held = '0;
    logic [38:0] now;
    low_cycles = 0;
    while (k < nwords && cyc < 3000) begin
      case (pat)
        0:       sif.counter_ready = 1'b1;
        1:       sif.counter_ready = (cyc % 2 == 0);
        default: sif.counter_ready = 1'($urandom_range(0, 1));
      endcase
      start  = 1'($urandom);
      mode   = 2'($urandom);
      frames = 8'($urandom);
      now = {sif.counter, sif.last_in_slice, sif.last_in_frame, sif.slice_idx, sif.counter_idx};
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL early_done word=%0d done=%b required 0", k, done);
      end
      if (stall && sif.counter_valid) begin
        checks++;
        if (now !== held) begin
          failures++;
          $display("FAIL stall_hold word=%0d got=%h required=%h", k, now, held);
        end
      end
      if (sif.counter_valid && sif.counter_ready) begin
        checks++;
        if (sif.counter !== ref_word(md, k) || sif.last_in_slice !== (k % NC == NC - 1) ||
            sif.last_in_frame !== (k % FW == FW - 1) || sif.slice_idx !== 2'((k % FW) / NC) ||
            sif.counter_idx !== 4'(k % NC)) begin
          failures++;
          $display("FAIL word mode=%0d k=%0d got cnt=%h lis=%b lif=%b sl=%0d ci=%0d required cnt=%h",
                   md, k, sif.counter, sif.last_in_slice, sif.last_in_frame, sif.slice_idx,
                   sif.counter_idx, ref_word(md, k));
        end
        if (rec) run1_q.push_back(sif.counter);
        k++;
        stall = 1'b0;
      end else if (sif.counter_valid) begin
        stall = 1'b1;
        held  = now;
      end else begin
        low_cycles++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (k != nwords) begin
      failures++;
      $display("FAIL stream_timeout words=%0d required=%0d", k, nwords);
    end
  endtask

  task automatic check_done_tail();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sif.counter_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b busy=%b valid=%b required 1 0 0", done, busy, sif.counter_valid);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sif.counter_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_tail done=%b busy=%b valid=%b required 0 0 0", done, busy, sif.counter_valid);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({sif.counter, sif.counter_valid, sif.last_in_slice, sif.last_in_frame,
         sif.slice_idx, sif.counter_idx, busy, done} !== 43'd0) begin
      failures++;
      $display("FAIL %s cnt=%h v=%b lis=%b lif=%b sl=%0d ci=%0d busy=%b done=%b required all 0",
               tag, sif.counter, sif.counter_valid, sif.last_in_slice, sif.last_in_frame,
               sif.slice_idx, sif.counter_idx, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    check_reset_vals("reset_state");
    reset = 1'b0;
    step();
    check_reset_vals("idle_no_start");
  endtask

  task automatic test_ramp_single();
    int low;
    do_start(2'd0, 8'd1);
    run_stream(0, FW, 0, 1'b0, low);
    checks++;
    if (low != 0) begin
      failures++;
      $display("FAIL ramp_gaps low=%0d required=0", low);
    end
    check_done_tail();
  endtask

  task automatic test_ramp_backpressure();
    int low;
    do_start(2'd0, 8'd2);
    run_stream(0, 2 * FW, 1, 1'b0, low);
    checks++;
    if (low != 1) begin
      failures++;
      $display("FAIL frame_gap low=%0d required=1", low);
    end
    check_done_tail();
  endtask

  task automatic test_sparse();
    int low;
    do_start(2'd3, 8'd1);
    run_stream(3, FW, 2, 1'b0, low);
    check_done_tail();
  endtask

  task automatic test_back_to_back();
    int low;
    logic [31:0] first;
    run1_q.delete();
    do_start(2'd2, 8'd1);
    first = SEED;
    checks++;
    if (sif.counter !== first) begin
      failures++;
      $display("FAIL lfsr_first got=%h required=%h", sif.counter, first);
    end
    run_stream(2, FW, 0, 1'b1, low);
    check_done_tail();
    do_start(2'd2, 8'd1);
    for (int i = 0; i < FW; i++) begin
      sif.counter_ready = 1'b1;
      checks++;
      if (sif.counter_valid !== 1'b1 || sif.counter !== run1_q[i]) begin
        failures++;
        $display("FAIL lfsr_repeat i=%0d got=%h required=%h", i, sif.counter, run1_q[i]);
      end
      step();
    end
    check_done_tail();
  endtask

  task automatic test_const_abort();
    int low;
    do_start(2'd1, 8'd0);
    run_stream(1, 15, 0, 1'b0, low);
    checks++;
    if (sif.counter !== 32'd2 || sif.counter_idx !== 4'd5 || sif.counter_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_word cnt=%h ci=%0d v=%b required 2 5 1", sif.counter, sif.counter_idx,
               sif.counter_valid);
    end
    sif.counter_ready = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.counter_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL after_abort cyc=%0d v=%b busy=%b done=%b required 0 0 0", i,
                 sif.counter_valid, busy, done);
      end
      step();
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (sif.counter_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_beats_start v=%b busy=%b required 0 0", sif.counter_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int low;
    do_start(2'd0, 8'd1);
    run_stream(0, 7, 0, 1'b0, low);
    reset = 1'b1;
    step();
    check_reset_vals("mid_reset");
    reset = 1'b0;
    step();
    do_start(2'd0, 8'd1);
    run_stream(0, FW, 2, 1'b0, low);
    check_done_tail();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 2'd0;
    frames = 8'd0;
    sif.counter_ready = 1'b0;
    test_reset();
    test_ramp_single();
    test_ramp_backpressure();
    test_sparse();
    test_back_to_back();
    test_const_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
